// File: rtl/lf64_pipelined_subtractor.sv
// Two-stage pipelined subtractor: diff = a - b - bin, evaluated as
// a + ~b + ~bin on a Ladner-Fischer prefix carry network. Stage 1 registers
// the generate/propagate vectors; stage 2 resolves carries and flags.
// A single advance enable (adv) moves both stages together, so a stalled
// consumer freezes the whole pipe without dropping or duplicating beats.
module lf64_pipelined_subtractor #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             adv;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic             s1_cin;
  logic             s1_amsb;
  logic             s1_bmsb;

  logic [WIDTH-1:0] g_pre;
  logic [WIDTH-1:0] p_pre;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] diff_nxt;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv & rst_n;

  // Stage 1: capture per-bit generate/propagate of a + ~b and the operand signs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_cin   <= 1'b0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid & in_ready;
      s1_p     <= a ^ ~b;
      s1_g     <= a & ~b;
      s1_cin   <= ~bin;
      s1_amsb  <= a[WIDTH-1];
      s1_bmsb  <= b[WIDTH-1];
    end
  end

  // Ladner-Fischer prefix tree: at level l, every bit with bit l of its index
  // set merges with the last bit of the preceding 2^l-aligned block.
  for (genvar l = 0; l < LEVELS; l++) begin : lvl
    logic [WIDTH-1:0] g_i;
    logic [WIDTH-1:0] p_i;
    logic [WIDTH-1:0] g_o;
    logic [WIDTH-1:0] p_o;

    if (l == 0) begin : src_in
      assign g_i = s1_g;
      assign p_i = s1_p;
    end else begin : src_prev
      assign g_i = lvl[l-1].g_o;
      assign p_i = lvl[l-1].p_o;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : node
      localparam int J = ((i >> l) << l) - 1;
      if (((i >> l) & 1) == 1) begin : merge
        assign g_o[i] = g_i[i] | (p_i[i] & g_i[J]);
        assign p_o[i] = p_i[i] & p_i[J];
      end else begin : pass
        assign g_o[i] = g_i[i];
        assign p_o[i] = p_i[i];
      end
    end
  end

  assign g_pre    = lvl[LEVELS-1].g_o;
  assign p_pre    = lvl[LEVELS-1].p_o;
  assign carry    = g_pre | ({WIDTH{s1_cin}} & p_pre);
  assign diff_nxt = s1_p ^ {carry[WIDTH-2:0], s1_cin};

  // Stage 2: register the difference and its flags; borrow is the inverted carry-out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      diff      <= diff_nxt;
      bout      <= ~carry[WIDTH-1];
      ovf       <= (s1_amsb ^ s1_bmsb) & (diff_nxt[WIDTH-1] ^ s1_amsb);
      zero      <= (diff_nxt == '0);
    end
  end

endmodule

// File: tb/tb_lf64_pipelined_subtractor.sv
// Bench for lf64_pipelined_subtractor: directed literal cases, a stall/ordering
// scenario, a mid-flight reset, and a randomized handshake run, all checked
// against a queue-based arithmetic model of a - b - bin.
module tb_lf64_pipelined_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  always #5 clk = ~clk;

  lf64_pipelined_subtractor #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  res_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;
  logic        hold_pend = 1'b0;
  res_t        held;
  logic [63:0] corner [4];

  // Plain arithmetic reference: wide unsigned and signed subtraction.
  function automatic res_t model(input logic [63:0] av, input logic [63:0] bv, input logic bi);
    res_t               r;
    logic signed [65:0] sr;
    r.d  = av - bv - {63'd0, bi};
    r.bo = ({1'b0, av} < ({1'b0, bv} + {64'd0, bi}));
    sr   = $signed({{2{av[63]}}, av}) - $signed({{2{bv[63]}}, bv}) - $signed({65'd0, bi});
    r.ov = (sr != $signed({{2{r.d[63]}}, r.d}));
    r.z  = (r.d == 64'd0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Compare process: handshake rule, stall hold, and output order vs. the model.
  always @(negedge clk) begin : mon
    res_t e;
    chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (out_ready | ~out_valid) & rst_n});
    if (hold_pend) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_diff", diff, held.d);
      chk("hold_flags", {61'd0, bout, ovf, zero}, {61'd0, held.bo, held.ov, held.z});
    end
    hold_pend = rst_n && out_valid && !out_ready;
    held      = '{d: diff, bo: bout, ov: ovf, z: zero};
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual=diff_%h required=no_beat", diff);
        end else begin
          e = q.pop_front();
          chk("model_diff", diff, e.d);
          chk("model_bout", {63'd0, bout}, {63'd0, e.bo});
          chk("model_ovf", {63'd0, ovf}, {63'd0, e.ov});
          chk("model_zero", {63'd0, zero}, {63'd0, e.z});
        end
        n_out++;
      end
      if (in_valid && in_ready) q.push_back(model(a, b, bin));
    end
  end

  // One beat into an empty pipe with out_ready=1; checks latency and literal result.
  task automatic single(input logic [63:0] av, input logic [63:0] bv, input logic bi,
                        input logic [63:0] ed, input logic eb, input logic eo, input logic ez);
    in_valid = 1'b1; a = av; b = bv; bin = bi;
    @(negedge clk);
    chk("acc_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    @(negedge clk);
    chk("lat_early", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    chk("lit_diff", diff, ed);
    chk("lit_bout", {63'd0, bout}, {63'd0, eb});
    chk("lit_ovf", {63'd0, ovf}, {63'd0, eo});
    chk("lit_zero", {63'd0, zero}, {63'd0, ez});
  endtask

  // Holds a beat until accepted; returns just after the accepting edge.
  task automatic push_beat(input logic [63:0] av, input logic [63:0] bv, input logic bi);
    logic done;
    done = 1'b0;
    in_valid = 1'b1; a = av; b = bv; bin = bi;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL push_timeout actual=not_accepted required=accepted");
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (q.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_idle", {63'd0, out_valid}, 64'd0);
  endtask

  function automatic logic [63:0] rnd_op(input logic [63:0] other);
    int mode;
    mode = $urandom_range(0, 5);
    case (mode)
      0, 1:    return {$urandom, $urandom};
      2:       return 64'($urandom_range(0, 255));
      3:       return other;
      default: return corner[$urandom_range(0, 3)];
    endcase
  endfunction

  initial begin
    int n0;
    corner[0] = 64'd0;
    corner[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    corner[2] = 64'h8000_0000_0000_0000;
    corner[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_flags", {61'd0, bout, ovf, zero}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    single(64'd25, 64'd10, 1'b0, 64'd15, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    single(64'd10, 64'd15, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    single(64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    single(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    single(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Four back-to-back beats with a three-cycle consumer stall.
    n0 = n_out;
    fork
      begin
        for (int k = 0; k < 4; k++)
          push_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
      begin
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", 64'(n_out - n0), 64'd4);

    // Reset with two beats in flight, then a fresh beat.
    @(posedge clk); #1;
    push_beat(64'd7, 64'd3, 1'b0);
    push_beat(64'd9, 64'd4, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_diff", diff, 64'd0);
    chk("mid_rst_flags", {61'd0, bout, ovf, zero}, 64'd0);
    @(posedge clk); #1;
    single(64'd100, 64'd1, 1'b0, 64'd99, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with random back-pressure and one short reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rst_n     = (cyc != 1500);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = rnd_op(b);
      b         = rnd_op(a);
      bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
